textgen_cell: RTL and testbench
===============================

Name: textgen_cell

Overview:
- Parametrised text-mode pixel generator for the VGA path.
- Per pixel coordinate from the timing generator, the block:
  - fetches character and attribute from an external text RAM;
  - fetches the glyph row from an external synchronous font ROM;
  - outputs a 12-bit RGB pixel with fixed pipeline latency.
- Adds the following:
  - configurable glyph size and integer pixel scaling;
  - per-cell colour attributes and blink;
  - hardware cursor;
  - sync/DE alignment.

Parameters:
- GLYPH_W, 8: glyph width in pixels. Power of two, 4..16.
- GLYPH_H, 8: glyph height in lines. Power of two, 8..32.
- SCALE, 1: pixel replication factor. Power of two, 1..4.
- COLS, 80: text columns.
- ROWS, 60: text rows.
- X_W, 11: pixel coordinate width.
- BLINK_BIT, 4: frame-counter bit used as blink phase. 2^(BLINK_BIT+1) frames per period.

Ports:
- clk_i  in  1  pixel clock
- rst_i  in  1  reset, asynchronous, active-high
- px_x_i  in  X_W  current pixel column
- px_y_i  in  X_W  current pixel line
- de_i  in  1  display enable
- hs_i  in  1  hsync
- vs_i  in  1  vsync, active-high
- txt_addr_o  out  TA_W = clog2(COLS*ROWS)  text RAM address
- txt_data_i  in  16  {attr[7:0], chr[7:0]}, valid one cycle after txt_addr_o
- rom_addr_o  out  8+clog2(GLYPH_H)  font ROM address {chr, glyph_line}
- rom_data_i  in  GLYPH_W  glyph row, valid one cycle after rom_addr_o. MSB is the leftmost pixel.
- cursor_en_i  in  1  cursor enable
- cursor_col_i  in  8  cursor text column
- cursor_row_i  in  8  cursor text row
- rgb_o  out  12  {R4,G4,B4}
- de_o  out  1  DE delayed to match rgb_o
- hs_o  out  1  hsync delayed to match rgb_o
- vs_o  out  1  vsync delayed to match rgb_o

Behaviour:
- All divisions are bit slices; every geometry parameter is a power of two.
  - col = px_x_i >> log2(GLYPH_W*SCALE)
  - sub_x = (px_x_i >> log2(SCALE)) mod GLYPH_W
  - row and sub_y are derived the same way from px_y_i and GLYPH_H.
- Pipeline, one register per stage, no stalls:
  - S1: register col, row, sub_x, sub_y, de, hs, vs and in_range = (col<COLS && row<ROWS). Drive txt_addr_o = row*COLS+col, registered. It is 0 when not in_range.
  - S2: txt_data_i valid. Register attr. Drive rom_addr_o = {chr, sub_y}, registered.
  - S3: rom_data_i valid. Select pixel bit rom_data_i[GLYPH_W-1-sub_x].
  - S4: resolve colour and register rgb_o.
- Latency is exactly 4 clocks from px_x_i/px_y_i/de_i/hs_i/vs_i to rgb_o/de_o/hs_o/vs_o. The sideband signals pass through the same 4 stages.
- Attribute fields:
  - fg = attr[3:0], palette index 0..15.
  - bg = attr[6:4], palette index 0..7.
  - blink = attr[7].
- Colour resolution, in priority order:
  1. de=0 or in_range=0 -> rgb_o = 12'h000.
  2. Cursor cell (cursor_en_i, col==cursor_col_i, row==cursor_row_i), sub_y >= GLYPH_H-2, blink phase 0 -> fg colour.
  3. Glyph bit 1, and not (blink=1 and phase=1) -> palette[fg].
  4. Otherwise -> palette[bg].
- Cursor inputs are sampled in S1, i.e. may change anytime. The change takes effect for pixels entering S1 after the change.
- Blink phase:
  - frame_cnt counts vs_i rising edges, edge detected with one register.
  - It is BLINK_BIT+1 bits wide and wraps to 0 at overflow.
  - phase = frame_cnt[BLINK_BIT].
  - phase is captured once per pixel in S3, so it never changes mid-pixel.
- Reset:
  - all pipeline registers, txt_addr_o, rom_addr_o, rgb_o, de_o, hs_o, vs_o = 0;
  - frame_cnt and vs edge register = 0.
  - Reset mid-frame: outputs are 0 immediately. Valid data resumes 4 clocks after release, with no recovery handshake.
- Out-of-range coordinates (e.g. 640x480 with COLS=100) never generate addresses outside the RAM.

Decomposition:
- Package textgen_pkg holds:
  - 16-entry CGA palette constant (12-bit);
  - attr field positions;
  - log2/clog2 helper functions;
  - the latency constant TEXTGEN_LAT = 4.
- Sub-module textgen_blink holds the vsync edge detector and frame counter, and outputs phase.
- Main module holds pipeline and colour resolution.

Test Plan:
- Defaults; RAM[0] = {8'h1F, 8'h41}; ROM row 0 of 'A' = 8'h18; sweep x=0..7, y=0 -> x=3,4 produce 12'hFFF (fg 15) and others 12'h00A (bg 1), each 4 clocks after input; de_o/hs_o track de_i/hs_i delayed 4.
- SCALE=2, GLYPH_H=16; drive x=0..15 -> each glyph bit is repeated for 2 consecutive pixels; y=20 gives rom_addr_o low bits = 10.
- attr=8'h9F (blink) -> glyph pixels white while frame_cnt[4]=0. After 16 vs_i rising edges they show the bg colour; the pattern repeats every 32 frames.
- cursor_en_i=1, cursor (2,1), GLYPH_H=8 -> pixels x=16..23, y=14..15 show fg during phase 0 and normal rendering during phase 1; lines y=8..13 are unaffected.
- px_x_i=700 with COLS=80 (col 87) -> txt_addr_o=0 and rgb_o=0; de_i=0 anywhere -> rgb_o=0.
- rst_i asserted mid-line for 3 cycles -> rgb_o, de_o, hs_o, vs_o, txt_addr_o and rom_addr_o read 0 asynchronously; the first valid pixel appears exactly 4 clocks after release.

Source files
------------

// File: rtl/textgen_pkg.sv
// Shared constants and helpers for the text-mode pixel generator.
// Holds the CGA palette, attribute field layout and log2 helpers.
package textgen_pkg;

  localparam int TEXTGEN_LAT = 4;

  localparam int ATTR_FG_LSB = 0;
  localparam int ATTR_BG_LSB = 4;
  localparam int ATTR_BLINK  = 7;

  localparam logic [11:0] CGA_PAL [0:15] = '{
    12'h000, 12'h00A, 12'h0A0, 12'h0AA,
    12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
    12'h555, 12'h55F, 12'h5F5, 12'h5FF,
    12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
  };

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Geometry is restricted to powers of two, so log2 is exact.
  function automatic int log2(input int v);
    return clog2(v);
  endfunction

endpackage

// File: rtl/textgen_blink.sv
// Blink phase source: counts vsync rising edges.
// The top bit of the frame counter is the blink phase.
module textgen_blink #(
  parameter int BLINK_BIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vs_i,
  output logic phase_o
);

  logic                 r_vs;
  logic [BLINK_BIT:0]   r_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vs  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_vs <= vs_i;
      if (vs_i && !r_vs)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign phase_o = r_cnt[BLINK_BIT];

endmodule

// File: rtl/textgen_cell.sv
// Text-mode pixel generator: text RAM -> font ROM -> palette.
// Four register stages, fixed latency, sideband aligned with rgb_o.
module textgen_cell
  import textgen_pkg::*;
#(
  parameter int GLYPH_W   = 8,
  parameter int GLYPH_H   = 8,
  parameter int SCALE     = 1,
  parameter int COLS      = 80,
  parameter int ROWS      = 60,
  parameter int X_W       = 11,
  parameter int BLINK_BIT = 4,
  localparam int TA_W     = clog2(COLS * ROWS),
  localparam int RA_W     = 8 + log2(GLYPH_H)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [X_W-1:0]   px_x_i,
  input  logic [X_W-1:0]   px_y_i,
  input  logic             de_i,
  input  logic             hs_i,
  input  logic             vs_i,
  output logic [TA_W-1:0]  txt_addr_o,
  input  logic [15:0]      txt_data_i,
  output logic [RA_W-1:0]  rom_addr_o,
  input  logic [GLYPH_W-1:0] rom_data_i,
  input  logic             cursor_en_i,
  input  logic [7:0]       cursor_col_i,
  input  logic [7:0]       cursor_row_i,
  output logic [11:0]      rgb_o,
  output logic             de_o,
  output logic             hs_o,
  output logic             vs_o
);

  localparam int GW_L = log2(GLYPH_W);
  localparam int GH_L = log2(GLYPH_H);
  localparam int SC_L = log2(SCALE);
  localparam int CW   = X_W - GW_L - SC_L;
  localparam int RW   = X_W - GH_L - SC_L;

  logic [CW-1:0]   w_col;
  logic [RW-1:0]   w_row;
  logic [GW_L-1:0] w_subx;
  logic [GH_L-1:0] w_suby;
  logic            w_inr;
  logic            w_cur;
  logic [TA_W-1:0] w_taddr;
  logic [GW_L-1:0] w_bidx;
  logic            w_phase;
  logic [11:0]     w_fg;
  logic [11:0]     w_bg;
  logic [11:0]     w_rgb;

  logic [GW_L-1:0] r1_subx, r2_subx;
  logic [GH_L-1:0] r1_suby;
  logic [2:0]      r1_sb, r2_sb, r3_sb;
  logic            r1_inr, r2_inr, r3_inr;
  logic            r1_cur, r2_cur, r3_cur;
  logic [7:0]      r2_attr, r3_attr;
  logic            r3_bit;
  logic            r3_phase;

  textgen_blink #(.BLINK_BIT(BLINK_BIT)) u_blink (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .vs_i    (vs_i),
    .phase_o (w_phase)
  );

  assign w_col  = px_x_i[X_W-1:GW_L+SC_L];
  assign w_row  = px_y_i[X_W-1:GH_L+SC_L];
  assign w_subx = px_x_i[SC_L +: GW_L];
  assign w_suby = px_y_i[SC_L +: GH_L];

  assign w_inr = (int'(w_col) < COLS) && (int'(w_row) < ROWS);
  assign w_cur = cursor_en_i
              && (int'(w_col) == int'(cursor_col_i))
              && (int'(w_row) == int'(cursor_row_i))
              && (int'(w_suby) >= GLYPH_H - 2);

  // Out-of-range cells address 0 so the RAM is never overrun.
  assign w_taddr = w_inr
    ? TA_W'(int'(w_row) * COLS + int'(w_col))
    : '0;

  assign w_bidx = GW_L'(GLYPH_W - 1) - r2_subx;

  assign w_fg = CGA_PAL[r3_attr[ATTR_FG_LSB +: 4]];
  assign w_bg = CGA_PAL[{1'b0, r3_attr[ATTR_BG_LSB +: 3]}];

  always_comb begin
    w_rgb = w_bg;
    if (!r3_sb[2] || !r3_inr)
      w_rgb = 12'h000;
    else if (r3_cur && !r3_phase)
      w_rgb = w_fg;
    else if (r3_bit && !(r3_attr[ATTR_BLINK] && r3_phase))
      w_rgb = w_fg;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r1_subx    <= '0;
      r1_suby    <= '0;
      r1_sb      <= '0;
      r1_inr     <= 1'b0;
      r1_cur     <= 1'b0;
      txt_addr_o <= '0;
      r2_subx    <= '0;
      r2_sb      <= '0;
      r2_inr     <= 1'b0;
      r2_cur     <= 1'b0;
      r2_attr    <= '0;
      rom_addr_o <= '0;
      r3_sb      <= '0;
      r3_inr     <= 1'b0;
      r3_cur     <= 1'b0;
      r3_attr    <= '0;
      r3_bit     <= 1'b0;
      r3_phase   <= 1'b0;
      rgb_o      <= '0;
      de_o       <= 1'b0;
      hs_o       <= 1'b0;
      vs_o       <= 1'b0;
    end else begin
      r1_subx    <= w_subx;
      r1_suby    <= w_suby;
      r1_sb      <= {de_i, hs_i, vs_i};
      r1_inr     <= w_inr;
      r1_cur     <= w_cur;
      txt_addr_o <= w_taddr;

      r2_subx    <= r1_subx;
      r2_sb      <= r1_sb;
      r2_inr     <= r1_inr;
      r2_cur     <= r1_cur;
      r2_attr    <= txt_data_i[15:8];
      rom_addr_o <= {txt_data_i[7:0], r1_suby};

      r3_sb      <= r2_sb;
      r3_inr     <= r2_inr;
      r3_cur     <= r2_cur;
      r3_attr    <= r2_attr;
      r3_bit     <= rom_data_i[w_bidx];
      r3_phase   <= w_phase;

      rgb_o      <= w_rgb;
      de_o       <= r3_sb[2];
      hs_o       <= r3_sb[1];
      vs_o       <= r3_sb[0];
    end
  end

endmodule

// File: tb/tb_textgen_cell.sv
// Directed bench for textgen_cell: default geometry plus a
// SCALE=2 / GLYPH_H=16 instance sharing the same pixel stream.
module tb_textgen_cell;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] px_x, px_y;
  logic        de, hs, vs;
  logic        cen;
  logic [7:0]  ccol, crow;

  logic [12:0] ta1, ta2;
  logic [15:0] td1, td2;
  logic [10:0] ra1;
  logic [11:0] ra2;
  logic [7:0]  rd1, rd2;
  logic [11:0] rgb1, rgb2;
  logic        de1, hs1, vs1, de2, hs2, vs2;

  typedef struct {
    logic [11:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic [11:0] rgb2;
    logic        c2;
  } exp_t;

  exp_t q[$];
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  assign td1 = (ta1 == 13'd1) ? 16'h9F41 : 16'h1F41;
  assign td2 = 16'h1F41;

  function automatic logic [7:0] font8(input logic [10:0] a);
    case (a)
      {8'h41, 3'd0}: return 8'h18;
      {8'h41, 3'd1}: return 8'h3C;
      {8'h41, 3'd2}: return 8'h66;
      {8'h41, 3'd3}: return 8'h66;
      {8'h41, 3'd4}: return 8'h7E;
      {8'h41, 3'd5}: return 8'h66;
      {8'h41, 3'd6}: return 8'h66;
      default:       return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] font16(input logic [11:0] a);
    case (a)
      {8'h41, 4'd0}:  return 8'h18;
      {8'h41, 4'd10}: return 8'hFF;
      default:        return 8'h00;
    endcase
  endfunction

  assign rd1 = font8(ra1);
  assign rd2 = font16(ra2);

  textgen_cell u_dut (
    .clk_i (clk), .rst_i (rst),
    .px_x_i (px_x), .px_y_i (px_y),
    .de_i (de), .hs_i (hs), .vs_i (vs),
    .txt_addr_o (ta1), .txt_data_i (td1),
    .rom_addr_o (ra1), .rom_data_i (rd1),
    .cursor_en_i (cen),
    .cursor_col_i (ccol), .cursor_row_i (crow),
    .rgb_o (rgb1), .de_o (de1), .hs_o (hs1), .vs_o (vs1)
  );

  textgen_cell #(.SCALE(2), .GLYPH_H(16)) u_dut2 (
    .clk_i (clk), .rst_i (rst),
    .px_x_i (px_x), .px_y_i (px_y),
    .de_i (de), .hs_i (hs), .vs_i (vs),
    .txt_addr_o (ta2), .txt_data_i (td2),
    .rom_addr_o (ra2), .rom_data_i (rd2),
    .cursor_en_i (cen),
    .cursor_col_i (ccol), .cursor_row_i (crow),
    .rgb_o (rgb2), .de_o (de2), .hs_o (hs2), .vs_o (vs2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one pixel; outputs after this edge belong to the item 3 back.
  task automatic cyc(input int x, input int y,
                     input logic d, input logic h, input logic v,
                     input logic [11:0] e1, input logic [11:0] e2,
                     input logic c2);
    exp_t e;
    px_x = 11'(x);
    px_y = 11'(y);
    de = d; hs = h; vs = v;
    q.push_back('{e1, d, h, v, e2, c2});
    @(posedge clk);
    #1;
    if (q.size() == 4) begin
      e = q.pop_front();
      chk("rgb", rgb1, e.rgb);
      chk("de",  de1,  e.de);
      chk("hs",  hs1,  e.hs);
      chk("vs",  vs1,  e.vs);
      if (e.c2) begin
        chk("rgb2", rgb2, e.rgb2);
        chk("de2",  de2,  e.de);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
  endtask

  task automatic vpulses(input int n);
    repeat (n) begin
      cyc(0, 0, 1'b0, 1'b0, 1'b1, 12'h000, 12'h000, 1'b0);
      cyc(0, 0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0);
    end
  endtask

  task automatic prefill();
    q.delete();
    repeat (3) q.push_back('{12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0});
  endtask

  initial begin
    px_x = '0; px_y = '0;
    de = 1'b0; hs = 1'b0; vs = 1'b0;
    cen = 1'b0; ccol = 8'd2; crow = 8'd1;

    #12;
    chk("rst_rgb", rgb1, 12'h000);
    chk("rst_de",  de1,  1'b0);
    chk("rst_ta",  ta1,  13'd0);
    chk("rst_ra",  ra1,  11'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    prefill();

    // phase 0 sweep: col0 normal, col1 blink attr
    for (int x = 0; x < 16; x++)
      cyc(x, 0, 1'b1, 1'(x % 2), 1'b0,
          (x == 3 || x == 4 || x == 11 || x == 12) ? 12'hFFF : 12'h00A,
          (x >= 6 && x <= 9) ? 12'hFFF : 12'h00A, 1'b1);
    idle(4);

    cyc(0, 20, 1'b1, 1'b0, 1'b0, 12'h00A, 12'hFFF, 1'b1);
    cyc(0, 20, 1'b1, 1'b0, 1'b0, 12'h00A, 12'hFFF, 1'b1);
    chk("rom2_line", ra2[3:0], 4'd10);
    chk("rom2_chr",  ra2[11:4], 8'h41);
    idle(4);

    cyc(700, 0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0);
    chk("ta_oor", ta1, 13'd0);
    cyc(8, 0, 1'b1, 1'b0, 1'b0, 12'h00A, 12'h000, 1'b0);
    chk("ta_c1", ta1, 13'd1);
    cyc(16, 8, 1'b1, 1'b0, 1'b0, 12'h00A, 12'h000, 1'b0);
    chk("ta_c82", ta1, 13'd82);
    cyc(3, 0, 1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0);
    idle(4);

    // cursor at (2,1), blink phase 0
    cen = 1'b1;
    for (int x = 16; x < 24; x++)
      cyc(x, 14, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b0);
    for (int x = 16; x < 24; x++)
      cyc(x, 15, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b0);
    for (int x = 16; x < 24; x++)
      cyc(x, 12, 1'b1, 1'b0, 1'b0,
          (x == 16 || x == 23) ? 12'h00A : 12'hFFF, 12'h000, 1'b0);
    cyc(24, 14, 1'b1, 1'b0, 1'b0, 12'h00A, 12'h000, 1'b0);
    cen = 1'b0;
    cyc(17, 15, 1'b1, 1'b0, 1'b0, 12'h00A, 12'h000, 1'b0);
    idle(4);

    // 16 frames -> phase 1
    vpulses(16);
    idle(3);
    for (int x = 0; x < 16; x++)
      cyc(x, 0, 1'b1, 1'b0, 1'b0,
          (x == 3 || x == 4) ? 12'hFFF : 12'h00A,
          (x >= 6 && x <= 9) ? 12'hFFF : 12'h00A, 1'b1);
    cen = 1'b1;
    for (int x = 16; x < 24; x++)
      cyc(x, 14, 1'b1, 1'b0, 1'b0,
          (x == 17 || x == 18 || x == 21 || x == 22) ? 12'hFFF : 12'h00A,
          12'h000, 1'b0);
    cyc(20, 15, 1'b1, 1'b0, 1'b0, 12'h00A, 12'h000, 1'b0);
    cen = 1'b0;
    idle(4);

    // 16 more frames -> wrap to phase 0
    vpulses(16);
    idle(3);
    for (int x = 8; x < 16; x++)
      cyc(x, 0, 1'b1, 1'b0, 1'b0,
          (x == 11 || x == 12) ? 12'hFFF : 12'h00A, 12'h000, 1'b0);
    idle(4);

    // reach phase 1, then reset mid-line
    vpulses(16);
    idle(3);
    repeat (5) cyc(3, 0, 1'b1, 1'b1, 1'b0, 12'hFFF, 12'hFFF, 1'b0);
    #2 rst = 1'b1;
    de = 1'b0; hs = 1'b0;
    #1;
    chk("arst_rgb", rgb1, 12'h000);
    chk("arst_de",  de1,  1'b0);
    chk("arst_hs",  hs1,  1'b0);
    chk("arst_vs",  vs1,  1'b0);
    chk("arst_ta",  ta1,  13'd0);
    chk("arst_ra",  ra1,  11'd0);
    chk("arst_rgb2", rgb2, 12'h000);
    chk("arst_hs2", hs2, 1'b0);
    chk("arst_vs2", vs2, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    prefill();
    cyc(11, 0, 1'b1, 1'b1, 1'b0, 12'hFFF, 12'h000, 1'b0);
    cyc(3, 0, 1'b1, 1'b0, 1'b0, 12'hFFF, 12'h000, 1'b0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
